token_divide_scheduler: RTL and testbench

Generalises serial token decimation (keep every k-th '1' token) to N_REQ independent serial token streams that share one output channel. Each stream has its own divide-phase counter and a small pending-token counter. A round-robin scheduler drains kept tokens onto a single valid/ready output tagged with the source id. It sits between per-lane token sources and a single downstream consumer, with a run-time divide ratio.

---
 rtl/token_sched_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/token_divide_scheduler.sv | 145 ++++++++++++++
 tb/tb_token_divide_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/token_sched_pkg.sv
// Shared constants, types and helpers for the token divide scheduler.
package token_sched_pkg;

    localparam int unsigned DROP_CNT_W  = 16;
    localparam int unsigned PEND_W_DFLT = 3;

    typedef logic [PEND_W_DFLT-1:0] pend_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned id_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, with wrap.
module rr_arbiter
    import token_sched_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt_oh,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             gnt_any
);

    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            idx = ID_W'((32'(ptr) + off) % N_REQ);
            if (!gnt_any && req[idx]) begin
                gnt_any     = 1'b1;
                gnt_idx     = idx;
                gnt_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/token_divide_scheduler.sv
// Per-stream token decimation with round-robin drain onto one valid/ready channel.
// Define TOKEN_SCHED_DROP_CNT_EN to enable the dropped-token counter on drop_cnt.
module token_divide_scheduler
    import token_sched_pkg::*;
#(
    parameter  int unsigned N_REQ   = 4,
    parameter  int unsigned DIV_W   = 4,
    parameter  int unsigned PEND_W  = PEND_W_DFLT,
    parameter  int unsigned DIV_RST = 2,
    localparam int unsigned ID_W    = id_w(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      tok,
    input  logic [DIV_W-1:0]      cfg_div,
    input  logic                  cfg_load,
    output logic                  out_valid,
    output logic [ID_W-1:0]       out_id,
    input  logic                  out_ready,
    output logic [N_REQ-1:0]      ovf,
    output logic                  idle,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [PEND_W-1:0] PendMax = '1;

    logic [DIV_W-1:0]  div_q, keff;
    logic [DIV_W-1:0]  phase_q [N_REQ];
    logic [DIV_W-1:0]  phase_d [N_REQ];
    logic [PEND_W-1:0] pend_q  [N_REQ];
    logic [PEND_W-1:0] pend_d  [N_REQ];
    logic [N_REQ-1:0]  keep, req, gnt_oh, dec, ovf_q, ovf_d;
    logic [ID_W-1:0]   rr_q, rr_d, gnt_idx, out_id_q, out_id_d;
    logic              out_valid_q, out_valid_d, gnt_any, free, load;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .req    (req),
        .ptr    (rr_q),
        .gnt_oh (gnt_oh),
        .gnt_idx(gnt_idx),
        .gnt_any(gnt_any)
    );

    assign keff = (div_q <= DIV_W'(1)) ? DIV_W'(1) : div_q;
    assign free = !out_valid_q || out_ready;
    assign load = free && gnt_any;
    assign dec  = load ? gnt_oh : '0;

    always_comb begin
        keep  = '0;
        req   = '0;
        ovf_d = ovf_q;
        for (int i = 0; i < N_REQ; i++) begin
            keep[i]    = tok[i] && (phase_q[i] == keff - DIV_W'(1));
            req[i]     = (pend_q[i] != '0);
            phase_d[i] = phase_q[i];
            pend_d[i]  = pend_q[i];
            // cfg_load wins over the token update, which still used the old phase.
            if (cfg_load) begin
                phase_d[i] = '0;
            end else if (tok[i]) begin
                phase_d[i] = keep[i] ? '0 : phase_q[i] + DIV_W'(1);
            end
            if (keep[i] && !dec[i]) begin
                if (pend_q[i] == PendMax) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + PEND_W'(1);
                end
            end else if (!keep[i] && dec[i]) begin
                pend_d[i] = pend_q[i] - PEND_W'(1);
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        rr_d        = rr_q;
        if (free) begin
            out_valid_d = gnt_any;
            if (gnt_any) begin
                out_id_d = gnt_idx;
                rr_d     = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q       <= DIV_W'(DIV_RST);
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            ovf_q       <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                phase_q[i] <= '0;
                pend_q[i]  <= '0;
            end
        end else begin
            if (cfg_load) begin
                div_q <= cfg_div;
            end
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            ovf_q       <= ovf_d;
            for (int i = 0; i < N_REQ; i++) begin
                phase_q[i] <= phase_d[i];
                pend_q[i]  <= pend_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign ovf       = ovf_q;
    assign idle      = !out_valid_q && (req == '0);

`ifdef TOKEN_SCHED_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_q, drop_inc;

    always_comb begin
        drop_inc = '0;
        for (int i = 0; i < N_REQ; i++) begin
            drop_inc = drop_inc + DROP_CNT_W'(tok[i] && !keep[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_q + drop_inc;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_token_divide_scheduler.sv
// Self-checking bench for token_divide_scheduler: vector table plus directed corner sequences.
module tb_token_divide_scheduler;
    import token_sched_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      tok;
    logic [3:0]      cfg_div;
    logic            cfg_load;
    logic            out_valid;
    logic [1:0]      out_id;
    logic            out_ready;
    logic [3:0]      ovf;
    logic            idle;
    logic [15:0]     drop_cnt;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int sb[$];

    typedef struct {
        logic [3:0] div;
        int         stream;
        int         ntok;
        int         exp;
    } vec_t;

    vec_t tbl[5];

    token_divide_scheduler u_dut (
        .clk      (clk),
        .rst      (rst),
        .tok      (tok),
        .cfg_div  (cfg_div),
        .cfg_load (cfg_load),
        .out_valid(out_valid),
        .out_id   (out_id),
        .out_ready(out_ready),
        .ovf      (ovf),
        .idle     (idle),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // Scoreboard: every handshake must match the next expected id.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            hs_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got id %0d, required no output", out_id);
            end else begin
                int e;
                e = sb.pop_front();
                if (int'(out_id) != e) begin
                    errors++;
                    $display("FAIL out_id: got %0d, required %0d", out_id, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [3:0] d);
        cfg_div  = d;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        sb.delete();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!idle && n < 200) begin
            step();
            n++;
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout: got idle %0d after %0d cycles, required 1", idle, n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int hs0;
        int lat;

        tbl[0] = '{div: 4'd3, stream: 1, ntok: 6,  exp: 2};
        tbl[1] = '{div: 4'd0, stream: 1, ntok: 5,  exp: 5};
        tbl[2] = '{div: 4'd2, stream: 3, ntok: 5,  exp: 2};
        tbl[3] = '{div: 4'd1, stream: 0, ntok: 3,  exp: 3};
        tbl[4] = '{div: 4'd7, stream: 2, ntok: 15, exp: 2};

        rst = 1'b0; tok = '0; cfg_div = '0; cfg_load = 1'b0; out_ready = 1'b1;
        step();
        step();
        rst = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_id", out_id, 0);
        check("rst_ovf", ovf, 0);
        check("rst_idle", idle, 1);
        check("rst_drop_cnt", drop_cnt, 0);

        // Default k=2 on stream 0: second and fourth tokens kept.
        hs0 = hs_cnt;
        lat = 0;
        sb.push_back(0);
        sb.push_back(0);
        for (int i = 0; i < 4; i++) begin
            tok = 4'b0001;
            step();
            if (lat == 0 && out_valid) lat = i + 1;
        end
        tok = '0;
        wait_idle();
        check("k2_first_valid_latency", lat, 3);
        check("k2_handshakes", hs_cnt - hs0, 2);
        check("k2_idle", idle, 1);

        for (int e = 0; e < 5; e++) begin
            do_cfg(tbl[e].div);
            hs0 = hs_cnt;
            for (int n = 0; n < tbl[e].exp; n++) sb.push_back(tbl[e].stream);
            for (int n = 0; n < tbl[e].ntok; n++) begin
                tok = '0;
                tok[tbl[e].stream] = 1'b1;
                step();
                tok = '0;
                step();
            end
            wait_idle();
            check($sformatf("tbl%0d_handshakes", e), hs_cnt - hs0, tbl[e].exp);
        end

        // Round-robin from pointer 0, then resume after the last grant.
        do_reset();
        do_cfg(4'd1);
        hs0 = hs_cnt;
        for (int i = 0; i < 4; i++) sb.push_back(i);
        tok = 4'b1111;
        step();
        tok = '0;
        repeat (5) step();
        check("rr_consecutive", hs_cnt - hs0, 4);
        sb.push_back(1);
        sb.push_back(2);
        tok = 4'b0110;
        step();
        tok = '0;
        wait_idle();
        check("rr_second_burst", hs_cnt - hs0, 6);

        // k=4 across all streams: three drops per stream.
        do_reset();
        do_cfg(4'd4);
        for (int i = 0; i < 4; i++) sb.push_back(i);
        repeat (4) begin
            tok = 4'b1111;
            step();
        end
        tok = '0;
        wait_idle();
`ifdef TOKEN_SCHED_DROP_CNT_EN
        check("drop_cnt", drop_cnt, 12);
`else
        check("drop_cnt", drop_cnt, 0);
`endif

        // Saturation: one token in the output register, seven pending, ninth lost.
        do_reset();
        do_cfg(4'd1);
        out_ready = 1'b0;
        hs0 = hs_cnt;
        for (int i = 0; i < 8; i++) sb.push_back(2);
        for (int i = 0; i < 9; i++) begin
            tok = 4'b0100;
            step();
            if (i == 7) check("ovf_not_yet", ovf, 0);
        end
        tok = '0;
        check("sat_out_valid", out_valid, 1);
        check("sat_out_id", out_id, 2);
        check("sat_ovf", ovf, 4'b0100);
        step();
        check("sat_hold_valid", out_valid, 1);
        check("sat_hold_id", out_id, 2);
        out_ready = 1'b1;
        wait_idle();
        check("sat_handshakes", hs_cnt - hs0, 8);

        // cfg_load with a token in the same cycle uses the old ratio and phase.
        do_cfg(4'd2);
        hs0 = hs_cnt;
        sb.push_back(0);
        tok = 4'b0001;
        step();
        cfg_div  = 4'd3;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        tok = 4'b0001;
        step();
        step();
        tok = '0;
        wait_idle();
        check("cfgld_old_ratio", hs_cnt - hs0, 1);
        sb.push_back(0);
        tok = 4'b0001;
        step();
        tok = '0;
        wait_idle();
        check("cfgld_new_ratio", hs_cnt - hs0, 2);
        check("ovf_sticky", ovf, 4'b0100);

        // Reset while a token is presented discards it.
        do_cfg(4'd1);
        out_ready = 1'b0;
        sb.push_back(1);
        tok = 4'b0010;
        step();
        tok = '0;
        step();
        check("pre_rst_valid", out_valid, 1);
        hs0 = hs_cnt;
        rst = 1'b0;
        step();
        rst = 1'b1;
        sb.delete();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_idle", idle, 1);
        check("mid_rst_ovf", ovf, 0);
        out_ready = 1'b1;
        repeat (3) step();
        check("mid_rst_no_hs", hs_cnt - hs0, 0);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
